// File: rtl/fpu_rnd_pkg.sv
// Shared types and constants for the rounder datapath: mask width, shift-amount width,
// and the packed record carried between the two mask-generator stages.
package fpu_rnd_pkg;

    localparam int MASK_LOG_W = 6;
    localparam int SH_W       = 13;
    localparam int MASK_W     = 2**MASK_LOG_W;

    typedef logic [MASK_W-1:0] mask_t;

    typedef struct packed {
        logic                  sign;
        logic                  sat;
        logic [MASK_LOG_W-1:0] shp;
    } mask_s1_t;

endpackage

// File: rtl/mask_gen_pipe_hdec.sv
// Combinational half-decoder: y[i] is set for every bit position strictly below x,
// producing a thermometer mask of x ones from the LSB upward.
module mask_hdec #(
    parameter int LOG_W = fpu_rnd_pkg::MASK_LOG_W
) (
    input  logic [LOG_W-1:0]    x,
    output logic [2**LOG_W-1:0] y
);

    generate
        for (genvar gi = 0; gi < 2**LOG_W; gi++) begin : g_bit
            localparam logic [LOG_W-1:0] IDX = LOG_W'(gi);
            assign y[gi] = (IDX < x);
        end
    endgenerate

endmodule

// File: rtl/mask_gen_pipe.sv
// Two-stage shift-mask generator with valid/ready flow control: converts a signed shift
// amount into keep mask v and shifted-out mask w, with saturation flag and tag passthrough.
module mask_gen_pipe #(
    parameter int LOG_W = fpu_rnd_pkg::MASK_LOG_W,
    parameter int SH_W  = fpu_rnd_pkg::SH_W,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SH_W-1:0]    in_sh,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2**LOG_W-1:0] out_v,
    output logic [2**LOG_W-1:0] out_w,
    output logic               out_sat,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int W     = 2**LOG_W;
    localparam int MAG_W = SH_W - 1;

    typedef struct packed {
        logic             sign;
        logic             sat;
        logic [LOG_W-1:0] shp;
    } s1_t;

    logic             adv1;
    logic             adv2;

    logic             s1_valid_reg;
    s1_t              s1_reg;
    logic [TAG_W-1:0] s1_tag_reg;

    logic             out_valid_reg;
    logic [W-1:0]     out_v_reg;
    logic [W-1:0]     out_w_reg;
    logic             out_sat_reg;
    logic [TAG_W-1:0] out_tag_reg;

    // A stage may load when it is empty or its contents leave this cycle.
    assign adv2     = !out_valid_reg || out_ready;
    assign adv1     = !s1_valid_reg || adv2;
    assign in_ready = adv1;

    // Stage 1: fold the signed amount into a magnitude and clamp it to W-1.
    logic [MAG_W-1:0] mag;
    logic             sat_next;
    s1_t              s1_next;

    always_comb begin
        mag           = in_sh[SH_W-2] ? ~in_sh[SH_W-2:0] : in_sh[SH_W-2:0];
        sat_next      = |mag[MAG_W-1:LOG_W];
        s1_next.sign  = in_sh[SH_W-1];
        s1_next.sat   = sat_next;
        s1_next.shp   = sat_next ? {LOG_W{1'b1}} : mag[LOG_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_reg       <= '0;
            s1_tag_reg   <= '0;
        end else if (adv1) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_reg     <= s1_next;
                s1_tag_reg <= in_tag;
            end
        end
    end

    // Stage 2: thermometer decode; negative shifts use the bit-reversed, one-extended form.
    logic [W-1:0] h;
    logic [W-1:0] h_ext;
    logic [W-1:0] h_rev;
    logic [W-1:0] u;
    logic [W-1:0] v_next;
    logic [W-1:0] w_next;

    mask_hdec #(
        .LOG_W (LOG_W)
    ) u_hdec (
        .x (s1_reg.shp),
        .y (h)
    );

    assign h_ext = {h[W-2:0], 1'b1};

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_rev
            assign h_rev[gi] = h_ext[W-1-gi];
        end
    endgenerate

    assign u      = s1_reg.sign ? h_rev : h;
    assign v_next = ~u;
    assign w_next = u & {W{s1_reg.sign}};

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_v_reg     <= '0;
            out_w_reg     <= '0;
            out_sat_reg   <= 1'b0;
            out_tag_reg   <= '0;
        end else if (adv2) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_v_reg   <= v_next;
                out_w_reg   <= w_next;
                out_sat_reg <= s1_reg.sat;
                out_tag_reg <= s1_tag_reg;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_v     = out_v_reg;
    assign out_w     = out_w_reg;
    assign out_sat   = out_sat_reg;
    assign out_tag   = out_tag_reg;

endmodule

// File: tb/tb_mask_gen_pipe.sv
// Directed and randomised checks of mask_gen_pipe (W=64, SH_W=13, TAG_W=4):
// golden values, latency, back-to-back throughput, stall/hold, reset flush.
module tb_mask_gen_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] in_sh;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_v;
    logic [63:0] out_w;
    logic        out_sat;
    logic [3:0]  out_tag;

    int vectors     = 0;
    int miscompares = 0;

    mask_gen_pipe #(
        .LOG_W (6),
        .SH_W  (13),
        .TAG_W (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sh     (in_sh),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_v     (out_v),
        .out_w     (out_w),
        .out_sat   (out_sat),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Independent reference: contiguous masks built from shifts rather than a decoder.
    function automatic void golden(input logic [12:0] sh, output logic [63:0] v,
                                   output logic [63:0] w, output logic sat);
        logic [11:0] t;
        int          shp;
        logic [63:0] u;
        t   = sh[11] ? ~sh[11:0] : sh[11:0];
        sat = (t > 12'd63);
        shp = sat ? 63 : int'(t);
        if (sh[12]) u = ~((64'd1 << (63 - shp)) - 64'd1);
        else        u = (64'd1 << shp) - 64'd1;
        v = ~u;
        w = sh[12] ? u : 64'd0;
    endfunction

    task automatic single(input string name, input logic [12:0] sh, input logic [3:0] tag,
                          input logic [63:0] ev, input logic [63:0] ew, input logic esat);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sh     = sh;
        in_tag    = tag;
        #1;
        check({name, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({name, "_lat1_valid"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check({name, "_v"}, out_v, ev);
        check({name, "_w"}, out_w, ew);
        check({name, "_sat"}, 64'(out_sat), 64'(esat));
        check({name, "_tag"}, 64'(out_tag), 64'(tag));
    endtask

    logic [132:0] exp_q[$];
    logic [132:0] exp_item;
    logic [132:0] cur_out;
    logic [132:0] prev_out;
    logic [63:0]  gv;
    logic [63:0]  gw;
    logic         gs;
    logic [12:0]  sh_r;
    bit           prev_hold;
    bit           acc;
    int           n_acc;
    int           sent;
    int           got;
    int           cyc;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_sh     = '0;
        in_tag    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_v", out_v, 64'd0);
        check("rst_out_w", out_w, 64'd0);
        check("rst_out_sat", 64'(out_sat), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        single("sh0",    13'd0,     4'd3,  64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0);
        single("sh5",    13'd5,     4'd4,  64'hFFFF_FFFF_FFFF_FFE0, 64'h0, 1'b0);
        single("neg0",   13'h1000,  4'd5,  64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0);
        single("sat256", 13'd256,   4'd6,  64'h8000_0000_0000_0000, 64'h0, 1'b1);
        single("t0",     13'h0FFF,  4'd7,  64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0);
        single("sh63",   13'd63,    4'd8,  64'h8000_0000_0000_0000, 64'h0, 1'b0);
        single("sh64",   13'd64,    4'd9,  64'h8000_0000_0000_0000, 64'h0, 1'b1);
        single("neg3",   13'h1003,  4'd10, 64'h0FFF_FFFF_FFFF_FFFF, 64'hF000_0000_0000_0000, 1'b0);
        single("negsat", 13'h1100,  4'd11, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

        // Back-to-back sh=0..7: one result per cycle, in order.
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = (k < 8);
            in_sh    = 13'(k);
            in_tag   = 4'(k);
            #1;
            if (k < 8) check("b2b_in_ready", 64'(in_ready), 64'd1);
            @(posedge clk); #1;
            if (k >= 1 && k <= 8) begin
                check("b2b_valid", 64'(out_valid), 64'd1);
                check("b2b_tag", 64'(out_tag), 64'(k - 1));
                check("b2b_v", out_v, ~((64'd1 << (k - 1)) - 64'd1));
            end
        end
        in_valid = 1'b0;
        check("b2b_idle", 64'(out_valid), 64'd0);

        // Stall: only two requests fit while out_ready is low.
        out_ready = 1'b0;
        n_acc     = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_sh    = 13'(10 + n_acc);
            in_tag   = 4'(12 + n_acc);
            #1;
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) n_acc++;
        end
        in_valid = 1'b0;
        check("stall_accepted", 64'(n_acc), 64'd2);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_tag", 64'(out_tag), 64'd12);
        check("stall_v", out_v, 64'hFFFF_FFFF_FFFF_FC00);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("drain_valid", 64'(out_valid), 64'd1);
        check("drain_tag", 64'(out_tag), 64'd13);
        check("drain_v", out_v, 64'hFFFF_FFFF_FFFF_F800);
        @(posedge clk); #1;
        check("drain_idle", 64'(out_valid), 64'd0);

        // Reset with two requests in flight discards both.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sh     = 13'd5;
        in_tag    = 4'd1;
        @(posedge clk); #1;
        in_sh     = 13'h1003;
        in_tag    = 4'd2;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        check("flight_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_v", out_v, 64'd0);
        check("mid_rst_w", out_w, 64'd0);
        check("mid_rst_sat", 64'(out_sat), 64'd0);
        check("mid_rst_tag", 64'(out_tag), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_no_ghost", 64'(out_valid), 64'd0);

        // Random sweep against the reference with random back-pressure.
        sent      = 0;
        got       = 0;
        cyc       = 0;
        prev_hold = 1'b0;
        prev_out  = '0;
        while ((sent < 10000 || got < sent) && cyc < 60000) begin
            sh_r = 13'($urandom);
            if ($urandom_range(1) == 1) sh_r[10:6] = sh_r[11] ? 5'h1F : 5'h00;
            in_valid  = (sent < 10000) && ($urandom_range(3) != 0);
            in_sh     = sh_r;
            in_tag    = 4'($urandom);
            out_ready = ($urandom_range(3) != 0);
            #1;
            cur_out = {out_v, out_w, out_sat, out_tag};
            if (prev_hold) begin
                vectors++;
                assert (out_valid === 1'b1 && cur_out === prev_out) else begin
                    miscompares++;
                    $error("FAIL hold: observed valid=%b %h expected valid=1 %h",
                           out_valid, cur_out, prev_out);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sweep_unexpected_out", 64'(out_valid), 64'd0);
                end else begin
                    exp_item = exp_q.pop_front();
                    vectors++;
                    assert (cur_out === exp_item) else begin
                        miscompares++;
                        $error("FAIL sweep_result #%0d: observed %h expected %h",
                               got, cur_out, exp_item);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                golden(in_sh, gv, gw, gs);
                exp_q.push_back({gv, gw, gs, in_tag});
                sent++;
            end
            prev_hold = out_valid && !out_ready;
            prev_out  = cur_out;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        check("sweep_sent", 64'(sent), 64'd10000);
        check("sweep_got", 64'(got), 64'd10000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
